fifo_read_ctrl: RTL and testbench
=================================

# fifo_read_ctrl

Parametrised read-domain controller for the dual-clock FIFO. It owns the Gray-coded read pointer and a multi-stage synchroniser for the incoming write pointer. It produces registered empty, almost-empty and occupancy flags, plus a sticky underflow flag. It sits in the read clock domain between the FIFO memory read port and the write-domain controller, which receives `rptr_gray`.

## Interface
- `ADDR_WIDTH`, 4: memory address width. Depth is 2^ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits.
- `SYNC_STAGES`, 2: flop count in the write-pointer synchroniser. Legal values are 2 to 4.
- `AEMPTY_THRESH`, 2: `ralmost_empty` asserts when occupancy ≤ this value. Legal range is 0 to 2^ADDR_WIDTH−1.

Ports:
- `clk` in, 1 bit: read clock.
- `rst` in, 1 bit: reset, synchronous, active-low; clock clk.
- `rinc` in, 1 bit: pop request.
- `r_wptr_gray` in, ADDR_WIDTH+1 bits: Gray write pointer, launched from the write clock domain and unsynchronised.
- `rptr_gray` out, ADDR_WIDTH+1 bits: registered Gray read pointer, sent to the write domain.
- `raddr` out, ADDR_WIDTH bits: memory read address, equal to the low bits of the binary read pointer.
- `rempty` out, 1 bit: registered empty flag.
- `ralmost_empty` out, 1 bit: registered almost-empty flag.
- `rcount` out, ADDR_WIDTH+1 bits: registered occupancy as seen from the read domain.
- `runderflow` out, 1 bit: sticky flag, set on a pop attempted while empty.

## Operation
- State registers:
  - binary read pointer `rbin` (ADDR_WIDTH+1 bits), with `rptr_gray` = rbin ^ (rbin >> 1);
  - synchroniser chain of SYNC_STAGES × (ADDR_WIDTH+1) bits, Gray values, never decoded before the last stage;
  - the flag registers.
- Pop acceptance: `pop = rinc & ~rempty`.
  - On pop, `rbin_next = rbin + 1`, wrapping modulo 2^(ADDR_WIDTH+1).
  - Otherwise `rbin_next = rbin`.
- Synchronised write pointer `wgray_s` is the last synchroniser stage; `wbin_s` = gray2bin(`wgray_s`).
- Empty: `rempty` ← (bin2gray(`rbin_next`) == `wgray_s`). The flag is computed from the next pointer, so a pop that drains the FIFO shows empty on the very next cycle.
- Occupancy: `rcount` ← (`wbin_s` − `rbin_next`) mod 2^(ADDR_WIDTH+1). The result is always ≤ 2^ADDR_WIDTH.
- Almost-empty: `ralmost_empty` ← (`wbin_s` − `rbin_next`) ≤ AEMPTY_THRESH.
- Underflow: `rinc & rempty` sets `runderflow`. The pointer does not move. Only reset clears the flag.
- `raddr` is combinational from the `rbin` register, with no logic after the register, so the memory sees a stable address.
- `rptr_gray` changes by exactly one bit per accepted pop. Holding it in a register is mandatory for clock-domain-crossing safety.

## Timing
- Values after a clock edge with `rst` = 0:
  - `rbin` = 0, `rptr_gray` = 0, `raddr` = 0;
  - all synchroniser stages = 0;
  - `rempty` = 1, `ralmost_empty` = 1, `rcount` = 0, `runderflow` = 0.
- Reset mid-operation discards all state on that edge, including any in-flight synchroniser contents. `rinc` during reset is ignored and does not set underflow.
- Write-to-visible latency: a change on `r_wptr_gray` is reflected in `rempty`, `rcount` and `ralmost_empty` SYNC_STAGES+1 clk edges later.
- Pop latency:
  - `raddr` and `rptr_gray` advance on the edge that samples the pop.
  - The flags reflect that pop on the same edge.
- Simultaneous write arrival and pop in one cycle: the flags use the new `wgray_s` and the new `rbin_next` together. There is no transient false-empty.
- Wrap-around: the MSB of the pointer toggles every 2^ADDR_WIDTH pops, and occupancy arithmetic stays correct across the wrap.
- Full FIFO: `rcount` = 2^ADDR_WIDTH (MSBs differ, low bits equal). `rempty` = 0.

## Structure
- Shared header `fifo_pkg.vh` holds:
  - `gray2bin` and `bin2gray` functions, parametrised by width;
  - default `ADDR_WIDTH` and `SYNC_STAGES` constants.
- The write-side controller uses the same header.
- One sub-module, `ptr_sync`, carries parameters WIDTH and STAGES. It is a plain flop chain with a synchronous active-low reset and is reused by the write side.
- No FSM is required. All logic is register-plus-next-state.

## Test plan
Bench uses ADDR_WIDTH=3, SYNC_STAGES=2, AEMPTY_THRESH=2.

1. **Reset:** hold rst=0 for 3 cycles with rinc=1. Expect rempty=1, ralmost_empty=1, rcount=0, rptr_gray=0, runderflow=0.
2. **Sync latency:** from empty, step r_wptr_gray through the Gray codes for 1, 2, 3, 4. Expect rcount to follow 3 edges after each step, reaching rcount=4, with ralmost_empty=0 and rempty=0.
3. **Drain:** with write pointer = 4, pulse rinc for 4 cycles. Expect raddr 0→1→2→3→4 and rcount 3, 2, 1, 0. ralmost_empty rises when rcount=2, and rempty=1 on the edge of the 4th pop.
4. **Underflow:** rinc=1 while empty. Expect the pointer unchanged and runderflow=1, held through 10 idle cycles and cleared only by reset.
5. **Wrap:** write pointer steps through 20 entries while 20 pops are interleaved. Expect rptr_gray MSB to toggle after pops 8 and 16, rptr_gray to change by exactly one bit per pop (checker), and final rcount=0.
6. **Full plus simultaneous write:** write pointer = 8 with rbin=0. Expect rcount=8 and rempty=0. Then pop while the write pointer moves to 9 in the same cycle; after sync, expect rcount=8.

Source files
------------

// File: rtl/fifo_read_ctrl_pkg.sv
// Shared definitions for the dual-clock FIFO controllers: default sizes and
// Gray/binary pointer conversions used by both the read and write sides.
package fifo_read_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH    = 4;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_AEMPTY_THRESH = 2;
    localparam int MAX_PTR_W         = 32;

    // Operates on a 32-bit container; callers zero-extend and truncate.
    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
        logic [MAX_PTR_W-1:0] b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_read_ctrl_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Values are passed through untouched; decoding happens after the last stage.
module ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller for the dual-clock FIFO: owns the read pointer,
// synchronises the write pointer and produces registered status flags.
module fifo_read_ctrl
    import fifo_read_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rinc,
    input  logic [ADDR_WIDTH:0]   r_wptr_gray,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   rcount,
    output logic                  runderflow
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wgray_s;
    logic [PW-1:0] wbin_s;
    logic [PW-1:0] occ_next;
    logic          pop;

    ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk (clk),
        .rst (rst),
        .d   (r_wptr_gray),
        .q   (wgray_s)
    );

    // Pop handshake: rinc is the request, ~rempty the acceptance; a pop
    // happens only on a cycle where both hold. rinc while empty is refused
    // and recorded in runderflow.
    assign pop        = rinc & ~rempty;
    assign rbin_next  = pop ? rbin + PW'(1) : rbin;
    assign rgray_next = PW'(bin2gray(MAX_PTR_W'(rbin_next)));
    assign wbin_s     = PW'(gray2bin(MAX_PTR_W'(wgray_s)));
    assign occ_next   = wbin_s - rbin_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rbin          <= '0;
            rptr_gray     <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rcount        <= '0;
            runderflow    <= 1'b0;
        end else begin
            rbin          <= rbin_next;
            rptr_gray     <= rgray_next;
            // Flags look at the next pointer so a draining pop shows empty at once.
            rempty        <= (rgray_next == wgray_s);
            ralmost_empty <= (occ_next <= PW'(AEMPTY_THRESH));
            rcount        <= occ_next;
            if (rinc && rempty) begin
                runderflow <= 1'b1;
            end
        end
    end

    assign raddr = rbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with ADDR_WIDTH=3, SYNC_STAGES=2,
// AEMPTY_THRESH=2: a vector table plus hand sequences for wrap and full cases.
module tb_fifo_read_ctrl;

    typedef struct {
        logic       rst;
        logic       rinc;
        logic [3:0] wg;
        logic       e_empty;
        logic       e_ae;
        logic [3:0] e_cnt;
        logic [3:0] e_rg;
        logic [2:0] e_addr;
        logic       e_uf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rinc;
    logic [3:0] r_wptr_gray;
    logic [3:0] rptr_gray;
    logic [2:0] raddr;
    logic       rempty;
    logic       ralmost_empty;
    logic [3:0] rcount;
    logic       runderflow;

    int   tests  = 0;
    int   failed = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fifo_read_ctrl #(
        .ADDR_WIDTH    (3),
        .SYNC_STAGES   (2),
        .AEMPTY_THRESH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rinc          (rinc),
        .r_wptr_gray   (r_wptr_gray),
        .rptr_gray     (rptr_gray),
        .raddr         (raddr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rcount        (rcount),
        .runderflow    (runderflow)
    );

    function automatic logic [3:0] gray(input int n);
        logic [3:0] b;
        b = 4'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic inc, input logic [3:0] w,
                       input logic e, input logic ae, input logic [3:0] c,
                       input logic [3:0] rg, input logic [2:0] a, input logic uf);
        vec_t v;
        v.rst = r; v.rinc = inc; v.wg = w;
        v.e_empty = e; v.e_ae = ae; v.e_cnt = c;
        v.e_rg = rg; v.e_addr = a; v.e_uf = uf;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b0; rinc = 1'b0; r_wptr_gray = 4'h0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] prev_rg;

        rst = 1'b0; rinc = 1'b1; r_wptr_gray = 4'h0;

        // Reset with rinc held high: rinc must be ignored.
        for (int i = 0; i < 3; i++) add(0, 1, 4'h0, 1, 1, 0, 4'h0, 0, 0);
        // Write pointer steps 1..4; each step visible three edges later.
        add(1, 0, 4'h1, 1, 1, 0, 4'h0, 0, 0);
        add(1, 0, 4'h1, 1, 1, 0, 4'h0, 0, 0);
        add(1, 0, 4'h1, 0, 1, 1, 4'h0, 0, 0);
        add(1, 0, 4'h3, 0, 1, 1, 4'h0, 0, 0);
        add(1, 0, 4'h3, 0, 1, 1, 4'h0, 0, 0);
        add(1, 0, 4'h3, 0, 1, 2, 4'h0, 0, 0);
        add(1, 0, 4'h2, 0, 1, 2, 4'h0, 0, 0);
        add(1, 0, 4'h2, 0, 1, 2, 4'h0, 0, 0);
        add(1, 0, 4'h2, 0, 0, 3, 4'h0, 0, 0);
        add(1, 0, 4'h6, 0, 0, 3, 4'h0, 0, 0);
        add(1, 0, 4'h6, 0, 0, 3, 4'h0, 0, 0);
        add(1, 0, 4'h6, 0, 0, 4, 4'h0, 0, 0);
        // Drain four entries.
        add(1, 1, 4'h6, 0, 0, 3, 4'h1, 1, 0);
        add(1, 1, 4'h6, 0, 1, 2, 4'h3, 2, 0);
        add(1, 1, 4'h6, 0, 1, 1, 4'h2, 3, 0);
        add(1, 1, 4'h6, 1, 1, 0, 4'h6, 4, 0);
        // Pop while empty: pointer holds, sticky underflow.
        add(1, 1, 4'h6, 1, 1, 0, 4'h6, 4, 1);
        for (int i = 0; i < 10; i++) add(1, 0, 4'h6, 1, 1, 0, 4'h6, 4, 1);
        add(0, 0, 4'h6, 1, 1, 0, 4'h0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; rinc = vecs[i].rinc; r_wptr_gray = vecs[i].wg;
            tick();
            check("rempty",        i, 32'(rempty),        32'(vecs[i].e_empty));
            check("ralmost_empty", i, 32'(ralmost_empty), 32'(vecs[i].e_ae));
            check("rcount",        i, 32'(rcount),        32'(vecs[i].e_cnt));
            check("rptr_gray",     i, 32'(rptr_gray),     32'(vecs[i].e_rg));
            check("raddr",         i, 32'(raddr),         32'(vecs[i].e_addr));
            check("runderflow",    i, 32'(runderflow),    32'(vecs[i].e_uf));
        end

        // Wrap: 20 writes with 20 interleaved pops.
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            r_wptr_gray = gray(i % 16);
            rinc = 1'b0;
            tick(); tick(); tick();
            check("wrap_cnt_pre", i, 32'(rcount), 32'd1);
            prev_rg = rptr_gray;
            rinc = 1'b1;
            tick();
            rinc = 1'b0;
            check("wrap_rg",     i, 32'(rptr_gray), 32'(gray(i % 16)));
            check("wrap_onebit", i, 32'($countones(prev_rg ^ rptr_gray)), 32'd1);
            check("wrap_msb",    i, 32'(rptr_gray[3]), 32'((i / 8) % 2));
        end
        check("wrap_cnt_final",   0, 32'(rcount), 32'd0);
        check("wrap_empty_final", 0, 32'(rempty), 32'd1);

        // Full FIFO, then a pop in the same cycle as a new write.
        do_reset();
        r_wptr_gray = 4'hC;
        tick(); tick(); tick();
        check("full_cnt",   0, 32'(rcount),        32'd8);
        check("full_empty", 0, 32'(rempty),        32'd0);
        check("full_ae",    0, 32'(ralmost_empty), 32'd0);
        rinc = 1'b1; r_wptr_gray = 4'hD;
        tick();
        rinc = 1'b0;
        check("simul_cnt0",  0, 32'(rcount),    32'd7);
        check("simul_raddr", 0, 32'(raddr),     32'd1);
        check("simul_rg",    0, 32'(rptr_gray), 32'h1);
        tick();
        check("simul_cnt1", 0, 32'(rcount), 32'd7);
        tick();
        check("simul_cnt2",  0, 32'(rcount), 32'd8);
        check("simul_empty", 0, 32'(rempty), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
